// File: rtl/sd_pio_in_irq_if.sv
// Register bus between a host and the sd_pio_in_irq edge-capture PIO block.
// Four 32-bit register slots, single-cycle writes, one-cycle registered read.
interface sd_pio_in_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sd_pio_in_irq.sv
// Edge-capturing parallel input port with maskable level interrupt.
// Optional per-bit debounce filter enabled by defining SD_PIO_DEBOUNCE_EN.
module sd_pio_in_irq #(
    parameter int DATA_W          = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    sd_pio_in_irq_if.slave    bus,
    input  logic [DATA_W-1:0] in_port,
    output logic              irq
);

    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
        $error("sd_pio_in_irq: DATA_W must be 1..32");
    end
    if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge_type
        $error("sd_pio_in_irq: EDGE_TYPE must be 0, 1 or 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("sd_pio_in_irq: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [DATA_W-1:0] r_sync1;
    logic [DATA_W-1:0] r_sync2;
    logic [1:0]        r_sync_vld;
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_vld;
    logic [DATA_W-1:0] r_edgecap;
    logic [DATA_W-1:0] r_irqmask;
    logic [31:0]       r_readdata;

    logic [DATA_W-1:0] w_flt;
    logic              w_flt_vld;
    logic [DATA_W-1:0] w_edge_raw;
    logic [DATA_W-1:0] w_edge;
    logic [DATA_W-1:0] w_clr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_wr;

    // The valid chain follows the first real samples through the pipeline so
    // reset values never masquerade as an input transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync_vld <= '0;
        end else begin
            r_sync1    <= in_port;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

`ifdef SD_PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic r_flt_vld;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flt_vld <= 1'b0;
        end else begin
            r_flt_vld <= r_sync_vld[1];
        end
    end

    assign w_flt_vld = r_flt_vld;

    genvar gi;
    for (gi = 0; gi < DATA_W; gi = gi + 1) begin : g_debounce
        logic [CNT_W-1:0] r_cnt;
        logic             r_flt_bit;

        // Until the first valid sample arrives the filter adopts the input
        // directly, so the post-reset level is not treated as a change.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt     <= '0;
                r_flt_bit <= 1'b0;
            end else if (!r_flt_vld) begin
                r_cnt     <= '0;
                r_flt_bit <= r_sync2[gi];
            end else if (r_sync2[gi] == r_flt_bit) begin
                r_cnt     <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt     <= '0;
                r_flt_bit <= r_sync2[gi];
            end else begin
                r_cnt     <= r_cnt + 1'b1;
            end
        end

        assign w_flt[gi] = r_flt_bit;
    end
`else
    assign w_flt     = r_sync2;
    assign w_flt_vld = r_sync_vld[1];
`endif

    if (EDGE_TYPE == 0) begin : g_rising
        assign w_edge_raw = w_flt & ~r_prev;
    end else if (EDGE_TYPE == 1) begin : g_falling
        assign w_edge_raw = ~w_flt & r_prev;
    end else begin : g_any
        assign w_edge_raw = w_flt ^ r_prev;
    end

    assign w_edge  = r_prev_vld ? w_edge_raw : '0;
    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_wdata = bus.writedata[DATA_W-1:0];
    assign w_clr   = (w_wr && bus.address == 2'd3) ? w_wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else begin
            r_prev     <= w_flt;
            r_prev_vld <= w_flt_vld;
        end
    end

    // A new edge wins over a simultaneous clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
        end else if (w_wr && bus.address == 2'd2) begin
            r_irqmask <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            case (bus.address)
                2'd0:    r_readdata <= 32'(w_flt);
                2'd2:    r_readdata <= 32'(r_irqmask);
                2'd3:    r_readdata <= 32'(r_edgecap);
                default: r_readdata <= '0;
            endcase
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = |(r_edgecap & r_irqmask);

endmodule
